// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 SEQ decode/write-back stage with 15-entry register file and sticky halt latch
module decode_writeback #(
    parameter int         NREGS  = 15,
    parameter logic [3:0] RSP_ID = 4'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic        halted,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] dbg_data
);

    // Register ID meaning "no register"; never stored in the file.
    localparam logic [3:0] R_NONE = 4'hF;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [63:0] regs [0:NREGS-1];
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        commit;

    // The function code only distinguishes cmov variants, which execute already folds into cnd.
    logic        ifun_unused;
    assign ifun_unused = ^ifun;

    // Source register selection from the instruction code.
    always_comb begin
        src_a = R_NONE;
        src_b = R_NONE;
        case (icode)
            I_RRMOVQ: src_a = rA;
            I_RMMOVQ: begin src_a = rA;     src_b = rB;     end
            I_MRMOVQ: src_b = rB;
            I_OPQ:    begin src_a = rA;     src_b = rB;     end
            I_CALL:   src_b = RSP_ID;
            I_RET:    begin src_a = RSP_ID; src_b = RSP_ID; end
            I_PUSHQ:  begin src_a = rA;     src_b = RSP_ID; end
            I_POPQ:   begin src_a = RSP_ID; src_b = RSP_ID; end
            default:  ;
        endcase
    end

    // Destination register selection; a not-taken cmov suppresses its E-port write.
    always_comb begin
        dst_e = R_NONE;
        dst_m = R_NONE;
        case (icode)
            I_RRMOVQ: dst_e = cnd ? rB : R_NONE;
            I_IRMOVQ: dst_e = rB;
            I_MRMOVQ: dst_m = rA;
            I_OPQ:    dst_e = rB;
            I_CALL:   dst_e = RSP_ID;
            I_RET:    dst_e = RSP_ID;
            I_PUSHQ:  dst_e = RSP_ID;
            I_POPQ:   begin dst_e = RSP_ID; dst_m = rA; end
            default:  ;
        endcase
    end

    assign dstE   = dst_e;
    assign dstM   = dst_m;
    assign commit = wb_en && !halted;

    // Combinational reads of pre-edge contents; ID F and reset both read as zero.
    always_comb begin
        valA     = 64'd0;
        valB     = 64'd0;
        dbg_data = 64'd0;
        if (rst_n) begin
            if (src_a != R_NONE)    valA     = regs[src_a];
            if (src_b != R_NONE)    valB     = regs[src_b];
            if (dbg_addr != R_NONE) dbg_data = regs[dbg_addr];
        end
    end

    // Register file commit; the M port takes priority when both ports target the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 64'd0;
            end
        end else if (commit) begin
            for (int i = 0; i < NREGS; i++) begin
                if (dst_m == 4'(i)) begin
                    regs[i] <= valM;
                end else if (dst_e == 4'(i)) begin
                    regs[i] <= valE;
                end
            end
        end
    end

    // Sticky halt latch, set by a committed halt and cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (commit && (icode == I_HALT)) begin
            halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// tb/tb_decode_writeback.sv - directed self-checking bench for decode_writeback
module tb_decode_writeback;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wb_en;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        halted;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;

    int total;
    int bad;

    decode_writeback #(.NREGS(15), .RSP_ID(4'd4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .icode    (icode),
        .ifun     (ifun),
        .rA       (rA),
        .rB       (rB),
        .cnd      (cnd),
        .valE     (valE),
        .valM     (valM),
        .wb_en    (wb_en),
        .valA     (valA),
        .valB     (valB),
        .dstE     (dstE),
        .dstM     (dstM),
        .halted   (halted),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply an instruction on the falling edge, half a cycle ahead of the commit edge.
    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic [63:0] ve, input logic [63:0] vm,
                         input logic en);
        @(negedge clk);
        icode = ic;
        ifun  = 4'h0;
        rA    = ra;
        rB    = rb;
        cnd   = c;
        valE  = ve;
        valM  = vm;
        wb_en = en;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
        tick();
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_halted: got %0b want 0", halted);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            total++;
            if (dbg_data !== 64'd0) begin
                bad++;
                $display("FAIL reset_reg%0d: got %h want 0", i, dbg_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_irmovq();
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'd0, 1'b1);
        total++;
        if (dstE !== 4'h2 || dstM !== 4'hF) begin
            bad++;
            $display("FAIL irmovq_dst: got dstE=%h dstM=%h want 2 F", dstE, dstM);
        end
        tick();
        dbg_addr = 4'h2;
        #1;
        total++;
        if (dbg_data !== 64'h1234) begin
            bad++;
            $display("FAIL irmovq_reg2: got %h want 1234", dbg_data);
        end
        drive(4'h6, 4'h2, 4'h2, 1'b0, 64'd0, 64'd0, 1'b0);
        total++;
        if (valA !== 64'h1234 || valB !== 64'h1234) begin
            bad++;
            $display("FAIL opq_read: got valA=%h valB=%h want 1234 1234", valA, valB);
        end
    endtask

    task automatic test_cmov();
        drive(4'h3, 4'hF, 4'h3, 1'b0, 64'hAA, 64'd0, 1'b1);
        tick();
        drive(4'h2, 4'h1, 4'h3, 1'b0, 64'd7, 64'd0, 1'b1);
        total++;
        if (dstE !== 4'hF) begin
            bad++;
            $display("FAIL cmov_nt_dstE: got %h want F", dstE);
        end
        tick();
        dbg_addr = 4'h3;
        #1;
        total++;
        if (dbg_data !== 64'hAA) begin
            bad++;
            $display("FAIL cmov_nt_reg3: got %h want aa", dbg_data);
        end
        drive(4'h2, 4'h1, 4'h3, 1'b1, 64'd7, 64'd0, 1'b1);
        total++;
        if (dstE !== 4'h3) begin
            bad++;
            $display("FAIL cmov_t_dstE: got %h want 3", dstE);
        end
        tick();
        #1;
        total++;
        if (dbg_data !== 64'd7) begin
            bad++;
            $display("FAIL cmov_t_reg3: got %h want 7", dbg_data);
        end
    endtask

    task automatic test_popq_rsp();
        drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'd0, 1'b1);
        tick();
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55, 1'b1);
        total++;
        if (valA !== 64'h100 || valB !== 64'h100) begin
            bad++;
            $display("FAIL popq_pre_read: got valA=%h valB=%h want 100 100", valA, valB);
        end
        total++;
        if (dstE !== 4'h4 || dstM !== 4'h4) begin
            bad++;
            $display("FAIL popq_dst: got dstE=%h dstM=%h want 4 4", dstE, dstM);
        end
        tick();
        dbg_addr = 4'h4;
        #1;
        total++;
        if (dbg_data !== 64'h55) begin
            bad++;
            $display("FAIL popq_reg4: got %h want 55", dbg_data);
        end
    endtask

    task automatic test_wben_invalid();
        drive(4'h3, 4'hF, 4'h1, 1'b0, 64'h11, 64'd0, 1'b1);
        tick();
        drive(4'h6, 4'h0, 4'h1, 1'b0, 64'd9, 64'd0, 1'b0);
        tick();
        dbg_addr = 4'h1;
        #1;
        total++;
        if (dbg_data !== 64'h11) begin
            bad++;
            $display("FAIL wben0_reg1: got %h want 11", dbg_data);
        end
        drive(4'hE, 4'h1, 4'h1, 1'b1, 64'h99, 64'h77, 1'b1);
        total++;
        if (valA !== 64'd0 || valB !== 64'd0) begin
            bad++;
            $display("FAIL invalid_read: got valA=%h valB=%h want 0 0", valA, valB);
        end
        total++;
        if (dstE !== 4'hF || dstM !== 4'hF) begin
            bad++;
            $display("FAIL invalid_dst: got dstE=%h dstM=%h want F F", dstE, dstM);
        end
        tick();
        #1;
        total++;
        if (dbg_data !== 64'h11 || halted !== 1'b0) begin
            bad++;
            $display("FAIL invalid_commit: got reg1=%h halted=%0b want 11 0", dbg_data, halted);
        end
    endtask

    task automatic test_halt();
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_pre: got %0b want 0", halted);
        end
        tick();
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_set: got %0b want 1", halted);
        end
        drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h5555, 64'd0, 1'b1);
        tick();
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'hBEEF, 64'd0, 1'b1);
        tick();
        dbg_addr = 4'h5;
        #1;
        total++;
        if (dbg_data !== 64'd0) begin
            bad++;
            $display("FAIL halt_reg5: got %h want 0", dbg_data);
        end
        dbg_addr = 4'h2;
        #1;
        total++;
        if (dbg_data !== 64'h1234 || halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_reg2: got reg2=%h halted=%0b want 1234 1", dbg_data, halted);
        end
    endtask

    task automatic test_reset_mid();
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h7777, 64'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        dbg_addr = 4'h2;
        #1;
        total++;
        if (dbg_data !== 64'd0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_immediate: got reg2=%h halted=%0b want 0 0", dbg_data, halted);
        end
        total++;
        if (dstE !== 4'h2) begin
            bad++;
            $display("FAIL rstmid_dstE: got %h want 2", dstE);
        end
        tick();
        total++;
        if (dbg_data !== 64'd0) begin
            bad++;
            $display("FAIL rstmid_held: got %h want 0", dbg_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h66, 64'd0, 1'b1);
        tick();
        dbg_addr = 4'h6;
        #1;
        total++;
        if (dbg_data !== 64'h66) begin
            bad++;
            $display("FAIL rst_first_commit: got %h want 66", dbg_data);
        end
        dbg_addr = 4'h3;
        #1;
        total++;
        if (dbg_data !== 64'd0) begin
            bad++;
            $display("FAIL rst_reg3_cleared: got %h want 0", dbg_data);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        icode    = 4'h1;
        ifun     = 4'h0;
        rA       = 4'hF;
        rB       = 4'hF;
        cnd      = 1'b0;
        valE     = 64'd0;
        valM     = 64'd0;
        wb_en    = 1'b0;
        dbg_addr = 4'hF;
        test_reset();
        test_irmovq();
        test_cmov();
        test_popq_rsp();
        test_wben_invalid();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
